branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Produces the per-fetch branch prediction (taken flag, target, hit) that the IF/ID and ID/EX stages carry forward to EX.
- Consumes EX's resolved branch outcome to train itself; it is the other end of the prediction protocol.
- Direct-mapped BTB with a 2-bit saturating counter per entry, plus resolution and misprediction statistics counters.
- Sits beside pc_reg/if_id; lookup is combinational from the current fetch PC, update is registered.

Parameters:
- INDEX_W, 6, log2 of entry count (64 entries); index = pc[INDEX_W+1:2].
- TAG_W, 24, tag width = 32-INDEX_W-2; tag = pc[31:INDEX_W+2].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pc_i  in  32  current fetch address.
- btb_hit_o  out  1  entry valid and tag match for pc_i.
- predict_taken_o  out  1  predicted direction (PredictTaken/PredictNotTaken).
- predict_addr_o  out  32  predicted next fetch address.
- upd_valid_i  in  1  EX resolved a conditional branch/jump this cycle.
- upd_pc_i  in  32  address of the resolved instruction.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  32  actual taken target.
- upd_mispredict_i  in  1  EX detected direction or target mismatch; qualified by upd_valid_i.
- stat_branch_cnt_o  out  32  resolved-branch count.
- stat_miss_cnt_o  out  32  misprediction count.

Behaviour:
- Storage per entry: valid bit, TAG_W tag, 32-bit target, 2-bit counter.
- Counter encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
- Reset (rst=1 at posedge): all valid=0, all counters=01, both stat counters=0.
- Outputs after reset: btb_hit_o=0, predict_taken_o=0, predict_addr_o=pc_i+4.
- Lookup (combinational, zero latency):
  - btb_hit_o = valid[idx] && tag[idx]==pc_i tag.
  - predict_taken_o = btb_hit_o && cnt[idx][1].
  - predict_addr_o = predict_taken_o ? target[idx] : pc_i+4 (32-bit wrap; 0xFFFFFFFC+4 = 0).
- Update (on posedge, upd_valid_i=1, rst=0), with u = upd_pc_i index:
  - Hit (valid[u] and tag match): counter +1 if upd_taken_i, else -1, saturating at 11 and 00. If taken, target[u] <= upd_target_i. Not taken leaves target unchanged.
  - Miss and taken: allocate (overwrite) the entry: valid=1, tag=upd tag, target=upd_target_i, counter=10.
  - Miss and not taken: no table change.
- Statistics:
  - stat_branch_cnt_o increments on each upd_valid_i.
  - stat_miss_cnt_o increments when upd_valid_i && upd_mispredict_i.
  - Both wrap from 0xFFFFFFFF to 0. upd_mispredict_i without upd_valid_i is ignored.
- Simultaneous lookup and update to the same index: the lookup returns pre-update state; the new state is visible from the next cycle. No bypass.
- Update concurrent with rst: rst wins; the update is discarded.
- Pipeline hold: no hold input. IF holds pc_i stable, so outputs remain stable unless an update changes the entry.
- Upd_pc_i bits [1:0] are ignored.
- Single update port; one update per cycle maximum.

Decomposition:
- defines.v gains:
  - BtbIndexW, BtbTagW.
  - Counter codes: CntSNT, CntWNT, CntWT, CntST.
  - Reuses the existing PredictTaken/PredictNotTaken and ZeroWord.
- Sub-module bp_sat_counter: combinational 2-bit next-state (cnt_i, taken_i -> cnt_o), instantiated once in the update path.
- Tables are flop arrays so that reset can clear them in one cycle.

Test Plan:
- Reset, then pc_i=0x80 -> btb_hit_o=0, predict_taken_o=0, predict_addr_o=0x84; both stats 0.
- Update pc=0x80 taken target=0x40, then lookup pc_i=0x80 next cycle -> hit=1, taken=1, addr=0x40, counter=10. Same-cycle lookup before the edge -> hit=0.
- Two not-taken updates to 0x80 from counter 10 -> 01, then 00. Lookup gives hit=1, taken=0, addr=0x84. A third not-taken update stays 00. Four taken updates saturate at 11.
- Alias: entry 0x80 valid; update pc=0x180 (same index, different tag) taken target=0x200. Lookup 0x80 -> hit=0; lookup 0x180 -> addr=0x200, counter=10. Not-taken update on a miss pc leaves the table unchanged.
- Issue 5 updates, 2 with upd_mispredict_i=1, plus 1 cycle with mispredict=1 and valid=0 -> branch_cnt=5, miss_cnt=2.
- Wrap/reset: preload branch_cnt=0xFFFFFFFF via updates or force, one update -> 0. Assert rst together with upd_valid_i -> table and stats cleared, the update is not applied.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared constants for the branch predictor slice: BTB geometry, 2-bit
// saturating counter codes, prediction direction codes and common words.
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

  // BTB geometry: 64 direct-mapped entries, tag is everything above the index.
  localparam int BtbIndexW = 6;
  localparam int BtbTagW   = 24;

  // 2-bit saturating counter codes; bit 1 is the predicted direction.
  localparam logic [1:0] CntSNT = 2'b00;
  localparam logic [1:0] CntWNT = 2'b01;
  localparam logic [1:0] CntWT  = 2'b10;
  localparam logic [1:0] CntST  = 2'b11;

  // Prediction direction codes.
  localparam logic PredictTaken    = 1'b1;
  localparam logic PredictNotTaken = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [31:0] InstStep = 32'h0000_0004;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// -----------------------------------------------------------------------------
// bp_sat_counter
// Combinational next-state for a 2-bit saturating direction counter.
//   cnt_i   : current counter value
//   taken_i : resolved branch direction
//   cnt_o   : counter value after training (saturates at 00 and 11)
// -----------------------------------------------------------------------------
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  // Step toward the resolved direction, holding at either end of the range.
  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != CntST) begin
        cnt_o = cnt_i + 2'b01;
      end else begin
        cnt_o = CntST;
      end
    end else begin
      if (cnt_i != CntSNT) begin
        cnt_o = cnt_i - 2'b01;
      end else begin
        cnt_o = CntSNT;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookup is combinational from the fetch PC; training from EX is registered,
// so a lookup in the same cycle as an update sees the pre-update entry.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   pc_i                 : current fetch address
//   btb_hit_o            : entry valid and tag matches pc_i
//   predict_taken_o      : predicted direction
//   predict_addr_o       : predicted next fetch address
//   upd_valid_i          : EX resolved a branch/jump this cycle
//   upd_pc_i             : address of the resolved instruction
//   upd_taken_i          : actual direction
//   upd_target_i         : actual taken target
//   upd_mispredict_i     : EX saw a mispredict (qualified by upd_valid_i)
//   stat_branch_cnt_o    : resolved-branch count (wraps)
//   stat_miss_cnt_o      : misprediction count (wraps)
// -----------------------------------------------------------------------------
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_W = BtbIndexW,
  parameter int TAG_W   = BtbTagW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        btb_hit_o,
  output logic        predict_taken_o,
  output logic [31:0] predict_addr_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_mispredict_i,
  output logic [31:0] stat_branch_cnt_o,
  output logic [31:0] stat_miss_cnt_o
);

  localparam int Entries = 1 << INDEX_W;

  // Tables are flop arrays so a single reset cycle clears every entry.
  logic             valid_tbl  [Entries];
  logic [TAG_W-1:0] tag_tbl    [Entries];
  logic [31:0]      target_tbl [Entries];
  logic [1:0]       cnt_tbl    [Entries];

  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;
  logic [1:0]         cnt_next;

  // Word-aligned fetch: the low two address bits never select an entry.
  logic unused_low_bits;
  assign unused_low_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

  assign lk_idx = pc_i[INDEX_W+1:2];
  assign lk_tag = pc_i[31:INDEX_W+2];
  assign up_idx = upd_pc_i[INDEX_W+1:2];
  assign up_tag = upd_pc_i[31:INDEX_W+2];

  // Lookup: hit, direction from counter MSB, and next-fetch address.
  always_comb begin
    btb_hit_o       = 1'b0;
    predict_taken_o = PredictNotTaken;
    predict_addr_o  = pc_i + InstStep;
    if (valid_tbl[lk_idx] && (tag_tbl[lk_idx] == lk_tag)) begin
      btb_hit_o = 1'b1;
      if (cnt_tbl[lk_idx][1]) begin
        predict_taken_o = PredictTaken;
        predict_addr_o  = target_tbl[lk_idx];
      end else begin
        predict_taken_o = PredictNotTaken;
        predict_addr_o  = pc_i + InstStep;
      end
    end else begin
      btb_hit_o       = 1'b0;
      predict_taken_o = PredictNotTaken;
      predict_addr_o  = pc_i + InstStep;
    end
  end

  // Hit check for the entry being trained.
  assign up_hit = valid_tbl[up_idx] && (tag_tbl[up_idx] == up_tag);

  bp_sat_counter u_sat_counter (
    .cnt_i   (cnt_tbl[up_idx]),
    .taken_i (upd_taken_i),
    .cnt_o   (cnt_next)
  );

  // Table training: hits train the counter, taken misses (re)allocate.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        valid_tbl[i] <= 1'b0;
        cnt_tbl[i]   <= CntWNT;
      end
    end else if (upd_valid_i) begin
      if (up_hit) begin
        cnt_tbl[up_idx] <= cnt_next;
        if (upd_taken_i) begin
          target_tbl[up_idx] <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        valid_tbl[up_idx]  <= 1'b1;
        tag_tbl[up_idx]    <= up_tag;
        target_tbl[up_idx] <= upd_target_i;
        cnt_tbl[up_idx]    <= CntWT;
      end
    end
  end

  // Statistics counters; both wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt <= ZeroWord;
      miss_cnt   <= ZeroWord;
    end else if (upd_valid_i) begin
      branch_cnt <= branch_cnt + 32'h0000_0001;
      if (upd_mispredict_i) begin
        miss_cnt <= miss_cnt + 32'h0000_0001;
      end
    end
  end

  assign stat_branch_cnt_o = branch_cnt;
  assign stat_miss_cnt_o   = miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Directed stimulus with hand-computed expectations pushed into a scoreboard
// queue; a monitor on the falling edge drains and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        btb_hit_o;
  logic        predict_taken_o;
  logic [31:0] predict_addr_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_mispredict_i;
  logic [31:0] stat_branch_cnt_o;
  logic [31:0] stat_miss_cnt_o;

  branch_predictor dut (
    .clk               (clk),
    .rst               (rst),
    .pc_i              (pc_i),
    .btb_hit_o         (btb_hit_o),
    .predict_taken_o   (predict_taken_o),
    .predict_addr_o    (predict_addr_o),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_mispredict_i  (upd_mispredict_i),
    .stat_branch_cnt_o (stat_branch_cnt_o),
    .stat_miss_cnt_o   (stat_miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_stat;
    logic        hit;
    logic        taken;
    logic [31:0] addr;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Expected statistics, tracked from the stimulus actually issued.
  logic [31:0] m_b;
  logic [31:0] m_m;

  // Monitor: drains this cycle's expectations at the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_stat) begin
        checks++;
        if (stat_branch_cnt_o !== e.bcnt) begin
          errors++;
          $display("FAIL %s.branch_cnt got=%h want=%h", e.name, stat_branch_cnt_o, e.bcnt);
        end
        checks++;
        if (stat_miss_cnt_o !== e.mcnt) begin
          errors++;
          $display("FAIL %s.miss_cnt got=%h want=%h", e.name, stat_miss_cnt_o, e.mcnt);
        end
      end else begin
        checks++;
        if (btb_hit_o !== e.hit) begin
          errors++;
          $display("FAIL %s.hit got=%b want=%b", e.name, btb_hit_o, e.hit);
        end
        checks++;
        if (predict_taken_o !== e.taken) begin
          errors++;
          $display("FAIL %s.taken got=%b want=%b", e.name, predict_taken_o, e.taken);
        end
        checks++;
        if (predict_addr_o !== e.addr) begin
          errors++;
          $display("FAIL %s.addr got=%h want=%h", e.name, predict_addr_o, e.addr);
        end
      end
    end
  end

  task automatic tick();
    if (rst) begin
      m_b = 32'h0;
      m_m = 32'h0;
    end else if (upd_valid_i) begin
      m_b = m_b + 32'h1;
      if (upd_mispredict_i) m_m = m_m + 32'h1;
    end
    @(posedge clk);
    #1;
    rst              = 1'b0;
    upd_valid_i      = 1'b0;
    upd_taken_i      = 1'b0;
    upd_mispredict_i = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken,
                     input logic [31:0] tgt, input logic mis);
    upd_valid_i      = 1'b1;
    upd_pc_i         = pc;
    upd_taken_i      = taken;
    upd_target_i     = tgt;
    upd_mispredict_i = mis;
  endtask

  task automatic expect_st(input string name, input logic [31:0] b, input logic [31:0] m);
    exp_t e;
    e.name = name; e.is_stat = 1'b1;
    e.hit = 1'b0; e.taken = 1'b0; e.addr = 32'h0;
    e.bcnt = b; e.mcnt = m;
    sb.push_back(e);
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic hit,
                      input logic taken, input logic [31:0] addr);
    exp_t e;
    pc_i = pc;
    e.name = name; e.is_stat = 1'b0;
    e.hit = hit; e.taken = taken; e.addr = addr;
    e.bcnt = 32'h0; e.mcnt = 32'h0;
    sb.push_back(e);
    expect_st({name, "_stats"}, m_b, m_m);
  endtask

  initial begin
    rst = 1'b1; pc_i = 32'h0;
    upd_valid_i = 1'b0; upd_pc_i = 32'h0; upd_taken_i = 1'b0;
    upd_target_i = 32'h0; upd_mispredict_i = 1'b0;
    m_b = 32'h0; m_m = 32'h0;
    tick();

    // Reset state and same-cycle lookup while the first entry is allocated.
    look("rst_lookup", 32'h0000_0080, 1'b0, 1'b0, 32'h0000_0084);
    expect_st("rst_stats_zero", 32'h0, 32'h0);
    upd(32'h0000_0080, 1'b1, 32'h0000_0040, 1'b1);
    tick();
    look("alloc", 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0040);       // cnt 10
    upd(32'h0000_0080, 1'b0, 32'h0000_0000, 1'b1);
    tick();
    look("wnt", 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0084);         // cnt 01
    upd(32'h0000_0080, 1'b0, 32'h0000_0000, 1'b0);
    tick();
    look("snt", 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0084);         // cnt 00
    upd(32'h0000_0080, 1'b0, 32'h0000_0000, 1'b0);
    tick();
    look("snt_sat", 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0084);     // stays 00
    upd(32'h0000_0080, 1'b1, 32'h0000_0040, 1'b0);
    tick();
    look("t1", 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0084);          // cnt 01
    upd(32'h0000_0080, 1'b1, 32'h0000_0040, 1'b0);
    tick();
    look("t2", 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0040);          // cnt 10
    upd(32'h0000_0080, 1'b1, 32'h0000_0044, 1'b0);
    tick();
    look("t3", 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0044);          // cnt 11
    upd(32'h0000_0080, 1'b1, 32'h0000_0048, 1'b1);
    tick();
    look("t4", 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0048);          // stays 11
    upd(32'h0000_0080, 1'b0, 32'h0000_0000, 1'b0);
    tick();
    look("st_sat", 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0048);      // cnt 10
    upd(32'h0000_0080, 1'b0, 32'h0000_0000, 1'b0);
    tick();
    look("back_wnt", 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0084);    // cnt 01

    // Alias: 0x180 shares the index of 0x80 with a different tag.
    upd(32'h0000_0180, 1'b1, 32'h0000_0200, 1'b0);
    tick();
    look("alias_old", 32'h0000_0080, 1'b0, 1'b0, 32'h0000_0084);
    tick();
    look("alias_new", 32'h0000_0180, 1'b1, 1'b1, 32'h0000_0200);
    upd(32'h0000_0180, 1'b0, 32'h0000_0000, 1'b0);
    tick();
    look("alias_cnt", 32'h0000_0180, 1'b1, 1'b0, 32'h0000_0184);   // 10 -> 01
    upd(32'h0000_0380, 1'b0, 32'h0000_0999, 1'b0);
    tick();
    look("miss_nt_keep", 32'h0000_0180, 1'b1, 1'b0, 32'h0000_0184);
    tick();
    look("miss_nt_noalloc", 32'h0000_0380, 1'b0, 1'b0, 32'h0000_0384);
    tick();
    look("pc_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

    // Reset together with an update: reset wins.
    upd(32'h0000_0080, 1'b1, 32'h0000_0040, 1'b1);
    rst = 1'b1;
    tick();
    look("rst_clear", 32'h0000_0180, 1'b0, 1'b0, 32'h0000_0184);
    expect_st("rst_clear_stats", 32'h0, 32'h0);
    tick();
    look("rst_discard", 32'h0000_0080, 1'b0, 1'b0, 32'h0000_0084);

    // Five updates (two mispredicts) plus one unqualified mispredict.
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        upd_mispredict_i = 1'b1;
      end else begin
        upd(32'h0000_1000, 1'b0, 32'h0000_0000, (i == 1 || i == 4) ? 1'b1 : 1'b0);
      end
      tick();
    end
    look("after_stats", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);
    expect_st("stats_5_2", 32'd5, 32'd2);
    tick();

    // Branch counter wrap from all-ones.
    force dut.branch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt;
    m_b = 32'hFFFF_FFFF;
    upd(32'h0000_1000, 1'b0, 32'h0000_0000, 1'b0);
    tick();
    expect_st("branch_wrap", 32'h0, 32'd2);
    tick();

    // Bounded drain of any outstanding expectations.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
